// File: rtl/alu_pkg.sv
// Opcode constants (funct encoding) and execute-stage state type shared by the ALU blocks.
package alu_pkg;

  localparam int unsigned CTL_W = 6;

  localparam logic [CTL_W-1:0] CTL_AND   = 6'd36;
  localparam logic [CTL_W-1:0] CTL_OR    = 6'd37;
  localparam logic [CTL_W-1:0] CTL_ADD   = 6'd32;
  localparam logic [CTL_W-1:0] CTL_SUB   = 6'd34;
  localparam logic [CTL_W-1:0] CTL_SLT   = 6'd42;
  localparam logic [CTL_W-1:0] CTL_SRL   = 6'd2;
  localparam logic [CTL_W-1:0] CTL_MULTU = 6'd25;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_e;

  // True for codes that complete in a single cycle; MULTU is handled separately.
  function automatic logic is_single_op(input logic [CTL_W-1:0] op);
    logic hit;
    case (op)
      CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_SRL: hit = 1'b1;
      default:                                             hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/alu_exec_mult_seq.sv
// Unsigned shift-add multiplier, one iteration per step; product_c/last_c expose the
// value the final step will write so the caller can capture it on that same edge.
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_c,
  output logic                 last_c
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH:0]     sum_c;

  // Upper half accumulates the multiplicand; lower half holds the remaining multiplier bits.
  assign sum_c     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign product_c = {sum_c, acc_q[WIDTH-1:1]};
  assign last_c    = (count_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (start_i) begin
      mcand_q <= a_i;
      acc_q   <= {WIDTH'(0), b_i};
      count_q <= '0;
    end else if (step_i) begin
      acc_q   <= product_c;
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT/SRL plus sequential MULTU into hi/lo.
// Define ALU_MULTU_EN to build the multiplier; otherwise MULTU is reported as illegal.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ctl,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             done_q;
  logic             illegal_q;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ill_c;

  // Single-cycle datapath; unsupported codes yield zero.
  always_comb begin
    alu_res_c = '0;
    alu_ill_c = !is_single_op(ctl);
    case (ctl)
      CTL_AND: alu_res_c = a & b;
      CTL_OR:  alu_res_c = a | b;
      CTL_ADD: alu_res_c = a + b;
      CTL_SUB: alu_res_c = a - b;
      CTL_SLT: alu_res_c = WIDTH'($signed(a) < $signed(b));
      CTL_SRL: alu_res_c = b >> shamt;
      default: alu_res_c = '0;
    endcase
  end

`ifdef ALU_MULTU_EN
  alu_state_e         state_q;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               mul_start_c;
  logic               mul_step_c;
  logic               mul_last_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  assign mul_start_c = start && (state_q == S_IDLE) && (ctl == CTL_MULTU);
  assign mul_step_c  = (state_q == S_MUL);

  mult_seq #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_c),
    .step_i   (mul_step_c),
    .a_i      (a),
    .b_i      (b),
    .product_c(mul_prod_c),
    .last_c   (mul_last_c)
  );

  // Requests are only looked at in IDLE, so anything presented while busy is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (ctl == CTL_MULTU) begin
              state_q   <= S_MUL;
              busy_q    <= 1'b1;
              illegal_q <= 1'b0;
            end else begin
              result_q  <= alu_res_c;
              zero_q    <= (alu_res_c == '0);
              illegal_q <= alu_ill_c;
              done_q    <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_last_c) begin
            hi_q     <= mul_prod_c[2*WIDTH-1:WIDTH];
            lo_q     <= mul_prod_c[WIDTH-1:0];
            result_q <= mul_prod_c[WIDTH-1:0];
            zero_q   <= (mul_prod_c[WIDTH-1:0] == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`else
  // Every request completes in one cycle; MULTU falls into the illegal path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= start;
      if (start) begin
        result_q  <= alu_res_c;
        zero_q    <= (alu_res_c == '0);
        illegal_q <= alu_ill_c;
      end
    end
  end

  assign busy = 1'b0;
  assign hi   = '0;
  assign lo   = '0;
`endif

  assign result  = result_q;
  assign zero    = zero_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expectations queued at issue, checked on each done pulse.
module tb_alu_exec;

  localparam int unsigned W = 32;
`ifdef ALU_MULTU_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   ctl;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   shamt;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic         illegal;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_exec #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl    (ctl),
    .start  (start),
    .a      (a),
    .b      (b),
    .shamt  (shamt),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done),
    .illegal(illegal),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           n_total = 0;
  int           n_bad = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result",  result,  mon_e.res);
        check("zero",    zero,    mon_e.zero);
        check("illegal", illegal, mon_e.ill);
        check("hi",      hi,      mon_e.hi);
        check("lo",      lo,      mon_e.lo);
        check("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // Called just after a negedge; drives one request for one cycle and queues its expectation.
  task automatic issue(input logic [5:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [4:0] sh);
    exp_t        e;
    logic [63:0] p;
    e.res = '0;
    e.ill = 1'b0;
    e.lat = 0;
    e.acc = cyc + 1;
    case (c)
      6'd36: e.res = av & bv;
      6'd37: e.res = av | bv;
      6'd32: e.res = av + bv;
      6'd34: e.res = av - bv;
      6'd42: e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      6'd2:  e.res = bv >> sh;
`ifdef ALU_MULTU_EN
      6'd25: begin
        p     = {32'd0, av} * {32'd0, bv};
        m_hi  = p[63:32];
        m_lo  = p[31:0];
        e.res = m_lo;
        e.lat = 32;
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    e.hi   = m_hi;
    e.lo   = m_lo;
    sb_q.push_back(e);
    ctl   = c;
    a     = av;
    b     = bv;
    shamt = sh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for the done cycle of a multiply, checking busy on the way.
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      check("busy_mul", busy, 1'b1);
      @(negedge clk);
      n++;
    end
    check("mul_timeout", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
  endtask

  task automatic run_op(input logic [5:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [4:0] sh);
    issue(c, av, bv, sh);
    if (MUL_EN && c == 6'd25) wait_done();
  endtask

  logic [5:0] rc;
  int         rk;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ctl   = '0;
    a     = '0;
    b     = '0;
    shamt = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (2) @(negedge clk);
    check("rst_result",  result,  32'd0);
    check("rst_zero",    zero,    1'b1);
    check("rst_busy",    busy,    1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_hi",      hi,      32'd0);
    check("rst_lo",      lo,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(6'd32, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("add_wrap_done", done, 1'b1);
    check("add_wrap_busy", busy, 1'b0);
    run_op(6'd42, 32'hFFFF_FFFE, 32'd1, 5'd0);
    run_op(6'd42, 32'd1, 32'hFFFF_FFFE, 5'd0);
    run_op(6'd34, 32'd5, 32'd7, 5'd0);
    run_op(6'd2,  32'd0, 32'h8000_0000, 5'd31);
    run_op(6'd36, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
    run_op(6'd37, 32'hF000_0000, 32'h0000_000F, 5'd0);
    run_op(6'd63, 32'd9, 32'd9, 5'd0);
    run_op(6'd25, 32'd6, 32'd7, 5'd0);
    run_op(6'd32, 32'd1, 32'd2, 5'd0);

    if (MUL_EN) begin
      run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      // A request pulsed mid-multiply, plus operand churn, must be ignored.
      issue(6'd25, 32'd3, 32'd4, 5'd0);
      repeat (3) @(negedge clk);
      ctl   = 6'd32;
      a     = 32'd99;
      b     = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 32'd7;
      b     = 32'd8;
      ctl   = 6'd63;
      wait_done();
      run_op(6'd32, 32'd10, 32'd20, 5'd0);
      run_op(6'd63, 32'd1, 32'd1, 5'd0);

      // Reset part-way through a multiply aborts it without a done pulse.
      issue(6'd25, 32'd1234, 32'd5678, 5'd0);
      repeat (9) @(negedge clk);
      check("abort_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_result",  result,  32'd0);
      check("abort_zero",    zero,    1'b1);
      check("abort_busy",    busy,    1'b0);
      check("abort_illegal", illegal, 1'b0);
      check("abort_hi",      hi,      32'd0);
      check("abort_lo",      lo,      32'd0);
      sb_q.delete();
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run_op(6'd25, 32'd2, 32'd3, 5'd0);
    end

    for (int i = 0; i < 30; i++) begin
      rk = $urandom_range(0, 7);
      case (rk)
        0: rc = 6'd36;
        1: rc = 6'd37;
        2: rc = 6'd32;
        3: rc = 6'd34;
        4: rc = 6'd42;
        5: rc = 6'd2;
        6: rc = 6'd25;
        default: rc = 6'($urandom_range(0, 63));
      endcase
      run_op(rc, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
